// File: rtl/accumulator_core_param.sv
// accumulator_core_param: parametrised accumulator CPU with a two-cycle
// fetch/execute FSM, its own register-file memory, a carry flag, a registered
// output port and a full-state scan chain.
// Optional breakpoint logic is enabled by defining ACCUM_CORE_BREAKPOINT_EN.
module accumulator_core_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_enable,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic              proc_en,
    output logic              halt,
`ifdef ACCUM_CORE_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    localparam int unsigned MemWords = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        StFetch   = 2'b00,
        StExec    = 2'b01,
        StHalt    = 2'b10,
        StHaltAlt = 2'b11  // only reachable by scan; treated as halted
    } state_e;

    localparam logic [3:0] OpLda   = 4'h0;
    localparam logic [3:0] OpSta   = 4'h1;
    localparam logic [3:0] OpAdd   = 4'h2;
    localparam logic [3:0] OpSub   = 4'h3;
    localparam logic [3:0] OpAnd   = 4'h4;
    localparam logic [3:0] OpOr    = 4'h5;
    localparam logic [3:0] OpXor   = 4'h6;
    localparam logic [3:0] OpAddi  = 4'h7;
    localparam logic [3:0] OpLdi   = 4'h8;
    localparam logic [3:0] OpJmp   = 4'h9;
    localparam logic [3:0] OpJz    = 4'hA;
    localparam logic [3:0] OpJc    = 4'hB;
    localparam logic [3:0] OpIn    = 4'hC;
    localparam logic [3:0] OpOut   = 4'hD;
    localparam logic [3:0] OpShift = 4'hE;
    localparam logic [3:0] OpHlt   = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] io_q, io_d;
    logic [DATA_W-1:0] mem_q [MemWords];
    logic [DATA_W-1:0] mem_d [MemWords];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W:0]   add_mem_sum;
    logic [DATA_W:0]   add_imm_sum;
    logic              zero;

    // Instruction decode and datapath helpers.
    always_comb begin
        opcode      = ir_q[DATA_W-1 -: 4];
        operand     = ir_q[ADDR_W-1:0];
        imm         = {{(DATA_W - ADDR_W){1'b0}}, operand};
        mem_rd      = mem_q[operand];
        add_mem_sum = {1'b0, acc_q} + {1'b0, mem_rd};
        add_imm_sum = {1'b0, acc_q} + {1'b0, imm};
        zero        = (acc_q == '0);
    end

    // Next-state logic: scan shifting takes priority over execution.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        c_d     = c_q;
        io_d    = io_q;
        mem_d   = mem_q;

        if (scan_enable) begin
            // One long shift register: each element's MSB feeds the next LSB.
            state_d  = state_e'({state_q[0], scan_in});
            pc_d     = (pc_q << 1) | ADDR_W'(state_q[1]);
            ir_d     = (ir_q << 1) | DATA_W'(pc_q[ADDR_W-1]);
            acc_d    = (acc_q << 1) | DATA_W'(ir_q[DATA_W-1]);
            c_d      = acc_q[DATA_W-1];
            io_d     = (io_q << 1) | DATA_W'(c_q);
            mem_d[0] = (mem_q[0] << 1) | DATA_W'(io_q[DATA_W-1]);
            for (int i = 1; i < MemWords; i++) begin
                mem_d[i] = (mem_q[i] << 1) | DATA_W'(mem_q[i-1][DATA_W-1]);
            end
        end else if (proc_en) begin
            unique case (state_q)
                StFetch: begin
`ifdef ACCUM_CORE_BREAKPOINT_EN
                    if (bp_en && (pc_q == bp_addr)) begin
                        state_d = StHalt;
                    end else begin
                        ir_d    = mem_q[pc_q];
                        pc_d    = pc_q + 1'b1;
                        state_d = StExec;
                    end
`else
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 1'b1;
                    state_d = StExec;
`endif
                end
                StExec: begin
                    state_d = StFetch;
                    unique case (opcode)
                        OpLda: acc_d = mem_rd;
                        OpSta: mem_d[operand] = acc_q;
                        OpAdd: {c_d, acc_d} = add_mem_sum;
                        OpSub: begin
                            acc_d = acc_q - mem_rd;
                            c_d   = (acc_q < mem_rd);
                        end
                        OpAnd: acc_d = acc_q & mem_rd;
                        OpOr:  acc_d = acc_q | mem_rd;
                        OpXor: acc_d = acc_q ^ mem_rd;
                        OpAddi: {c_d, acc_d} = add_imm_sum;
                        OpLdi: acc_d = imm;
                        OpJmp: pc_d = operand;
                        OpJz: begin
                            if (zero) pc_d = operand;
                        end
                        OpJc: begin
                            if (c_q) pc_d = operand;
                        end
                        OpIn:  acc_d = io_in;
                        OpOut: io_d = acc_q;
                        OpShift: begin
                            if (operand[0]) begin
                                c_d   = acc_q[0];
                                acc_d = acc_q >> 1;
                            end else begin
                                c_d   = acc_q[DATA_W-1];
                                acc_d = acc_q << 1;
                            end
                        end
                        OpHlt: state_d = StHalt;
                    endcase
                end
                StHalt, StHaltAlt: begin
                    // Halted: nothing changes until reset or rescan.
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            io_q    <= '0;
            for (int i = 0; i < MemWords; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            io_q    <= io_d;
            mem_q   <= mem_d;
        end
    end

    // Outputs.
    always_comb begin
        halt     = state_q[1];
        io_out   = io_q;
        scan_out = mem_q[MemWords-1][DATA_W-1];
    end

endmodule

// File: tb/tb_accumulator_core_param.sv
// Self-checking bench for accumulator_core_param at default parameters.
module tb_accumulator_core_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NW    = 16;
    localparam int O_PC  = 2;
    localparam int O_IR  = 6;
    localparam int O_ACC = 14;
    localparam int O_C   = 22;
    localparam int O_IO  = 23;
    localparam int O_MEM = 31;
    localparam int L     = 159;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          scan_enable = 1'b0;
    logic          scan_in = 1'b0;
    logic          scan_out;
    logic          proc_en = 1'b0;
    logic          halt;
    logic [DW-1:0] io_in = '0;
    logic [DW-1:0] io_out;

    int checks = 0;
    int failures = 0;

    accumulator_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .proc_en     (proc_en),
        .halt        (halt),
        .io_in       (io_in),
        .io_out      (io_out)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_st, m_pc, m_ir, m_acc, m_c, m_io;
    logic [7:0] m_mem [NW];

    typedef struct {
        logic [7:0] ins;
        logic [7:0] acc0;
        logic       c0;
        logic [7:0] memv;
        logic [7:0] eacc;
        logic       ec;
        logic [3:0] epc;
        logic [1:0] est;
        logic [7:0] eio;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] ins, input logic [7:0] acc0, input logic c0,
                                input logic [7:0] memv, input logic [7:0] eacc, input logic ec,
                                input logic [3:0] epc, input logic [1:0] est,
                                input logic [7:0] eio);
        vec_t v;
        v.ins = ins; v.acc0 = acc0; v.c0 = c0; v.memv = memv;
        v.eacc = eacc; v.ec = ec; v.epc = epc; v.est = est; v.eio = eio;
        return v;
    endfunction

    function automatic logic [L-1:0] pack(input int st, input int pc, input int ir, input int acc,
                                          input int c, input int io, input logic [7:0] m [NW]);
        logic [L-1:0] v;
        v = '0;
        v[1:0]          = 2'(st);
        v[O_PC +: AW]   = 4'(pc);
        v[O_IR +: DW]   = 8'(ir);
        v[O_ACC +: DW]  = 8'(acc);
        v[O_C]          = 1'(c);
        v[O_IO +: DW]   = 8'(io);
        for (int i = 0; i < NW; i++) v[O_MEM + i*DW +: DW] = m[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic scan_load(input logic [L-1:0] v);
        proc_en = 1'b0;
        scan_enable = 1'b1;
        for (int i = L - 1; i >= 0; i--) begin
            scan_in = v[i];
            tick();
        end
        scan_enable = 1'b0;
        scan_in = 1'b0;
    endtask

    // Shifts the whole chain out while feeding it back, so state is kept.
    task automatic scan_read(output logic [L-1:0] v);
        proc_en = 1'b0;
        scan_enable = 1'b1;
        for (int i = L - 1; i >= 0; i--) begin
            v[i] = scan_out;
            scan_in = scan_out;
            tick();
        end
        scan_enable = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic run(input int n);
        proc_en = 1'b1;
        repeat (n) tick();
        proc_en = 1'b0;
    endtask

    // One clock of the architectural model with proc_en high.
    function automatic void model_step(input int inv);
        int op, a, s;
        if (m_st == 0) begin
            m_ir = m_mem[m_pc];
            m_pc = (m_pc + 1) % NW;
            m_st = 1;
        end else if (m_st == 1) begin
            op = m_ir / 16;
            a  = m_ir % 16;
            m_st = 0;
            case (op)
                0: m_acc = m_mem[a];
                1: m_mem[a] = 8'(m_acc);
                2: begin s = m_acc + m_mem[a]; m_acc = s % 256; m_c = (s >= 256); end
                3: begin m_c = (m_acc < m_mem[a]); m_acc = (m_acc - m_mem[a] + 256) % 256; end
                4: m_acc = m_acc & m_mem[a];
                5: m_acc = m_acc | m_mem[a];
                6: m_acc = m_acc ^ m_mem[a];
                7: begin s = m_acc + a; m_acc = s % 256; m_c = (s >= 256); end
                8: m_acc = a;
                9: m_pc = a;
                10: if (m_acc == 0) m_pc = a;
                11: if (m_c != 0) m_pc = a;
                12: m_acc = inv;
                13: m_io = m_acc;
                14: begin
                    if (a % 2 == 0) begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
                    else begin m_c = m_acc % 2; m_acc = m_acc / 2; end
                end
                default: m_st = 2;
            endcase
        end
    endfunction

    initial begin
        logic [7:0]   pm [NW];
        logic [L-1:0] rb, rb2, exp_v, rv;
        logic [7:0]   a;

        // Reset state.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_halt", 256'(halt), 256'(0));
        check("reset_io_out", 256'(io_out), 256'(0));
        scan_read(rb);
        check("reset_chain", 256'(rb), 256'(0));

        // Single-instruction vectors: mem[0]=ins, operand word preloaded.
        tbl.push_back(mk(8'h29, 8'hF0, 0, 8'h20, 8'h10, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'hBC, 8'h10, 1, 8'h00, 8'h10, 1, 4'hC, 2'd0, 8'h00));
        tbl.push_back(mk(8'hB5, 8'h10, 0, 8'h00, 8'h10, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h32, 8'h03, 0, 8'h05, 8'hFE, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h33, 8'h09, 1, 8'h04, 8'h05, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'hE2, 8'h80, 0, 8'h00, 8'h00, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'hE1, 8'h03, 0, 8'h00, 8'h01, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'hA7, 8'h00, 1, 8'h00, 8'h00, 1, 4'h7, 2'd0, 8'h00));
        tbl.push_back(mk(8'hA7, 8'h01, 0, 8'h00, 8'h01, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h05, 8'h11, 1, 8'h5A, 8'h5A, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h44, 8'hF0, 0, 8'h3C, 8'h30, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h54, 8'hF0, 1, 8'h3C, 8'hFC, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h64, 8'hF0, 0, 8'h3C, 8'hCC, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h7F, 8'hF5, 0, 8'h00, 8'h04, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h73, 8'h05, 1, 8'h00, 8'h08, 0, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h85, 8'h77, 1, 8'h00, 8'h05, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'h9F, 8'h12, 0, 8'h00, 8'h12, 0, 4'hF, 2'd0, 8'h00));
        tbl.push_back(mk(8'hC3, 8'h12, 1, 8'h00, 8'h6B, 1, 4'h1, 2'd0, 8'h00));
        tbl.push_back(mk(8'hD3, 8'h39, 0, 8'h00, 8'h39, 0, 4'h1, 2'd0, 8'h39));
        tbl.push_back(mk(8'hF0, 8'h42, 0, 8'h00, 8'h42, 0, 4'h1, 2'd2, 8'h00));

        io_in = 8'h6B;
        foreach (tbl[k]) begin
            for (int i = 0; i < NW; i++) pm[i] = 8'h00;
            pm[0] = tbl[k].ins;
            if (tbl[k].ins[3:0] != 4'h0) pm[tbl[k].ins[3:0]] = tbl[k].memv;
            scan_load(pack(0, 0, 0, tbl[k].acc0, tbl[k].c0, 0, pm));
            run(2);
            check($sformatf("vec%0d_halt", k), 256'(halt), 256'(tbl[k].est[1]));
            scan_read(rb);
            check($sformatf("vec%0d_state", k),
                  256'({rb[1:0], rb[O_PC +: AW], rb[O_ACC +: DW], rb[O_C], rb[O_IO +: DW]}),
                  256'({tbl[k].est, tbl[k].epc, tbl[k].eacc, tbl[k].ec, tbl[k].eio}));
        end

        // Program LDI 5, ADDI 3, OUT, HLT.
        for (int i = 0; i < NW; i++) pm[i] = 8'h00;
        pm[0] = 8'h85; pm[1] = 8'h73; pm[2] = 8'hD0; pm[3] = 8'hF0;
        scan_load(pack(0, 0, 0, 0, 0, 0, pm));
        run(5);
        check("prog_io_c5", 256'(io_out), 256'(0));
        run(1);
        check("prog_io_c6", 256'(io_out), 256'(8));
        run(1);
        check("prog_halt_c7", 256'(halt), 256'(0));
        run(1);
        check("prog_halt_c8", 256'(halt), 256'(1));
        run(4);
        scan_read(rb);
        check("prog_final", 256'(rb), 256'(pack(2, 4, 8'hF0, 8, 0, 8, pm)));

        // ADD then JC.
        for (int i = 0; i < NW; i++) pm[i] = 8'h00;
        pm[0] = 8'h29; pm[1] = 8'hBC; pm[9] = 8'h20;
        scan_load(pack(0, 0, 0, 8'hF0, 0, 0, pm));
        run(4);
        scan_read(rb);
        check("add_jc", 256'(rb), 256'(pack(0, 12, 8'hBC, 8'h10, 1, 0, pm)));

        // PC wrap: JMP F; mem[15] = LDI 1.
        for (int i = 0; i < NW; i++) pm[i] = 8'h00;
        pm[0] = 8'h9F; pm[15] = 8'h81;
        scan_load(pack(0, 0, 0, 0, 0, 0, pm));
        run(3);
        scan_read(rb);
        check("wrap_pc", 256'(rb), 256'(pack(1, 0, 8'h81, 0, 0, 0, pm)));
        run(2);
        scan_read(rb);
        check("wrap_refetch", 256'(rb), 256'(pack(1, 1, 8'h9F, 1, 0, 0, pm)));

        // Freeze with proc_en low, then reset during EXEC.
        for (int i = 0; i < NW; i++) pm[i] = 8'h00;
        pm[0] = 8'h85; pm[1] = 8'h73; pm[2] = 8'hD0; pm[3] = 8'hF0;
        scan_load(pack(0, 0, 0, 0, 0, 0, pm));
        run(3);
        exp_v = pack(1, 2, 8'h73, 5, 0, 0, pm);
        proc_en = 1'b0;
        repeat (5) tick();
        scan_read(rb);
        check("freeze", 256'(rb), 256'(exp_v));
        rst = 1'b1;
        proc_en = 1'b1;
        tick();
        rst = 1'b0;
        proc_en = 1'b0;
        check("rst_halt", 256'(halt), 256'(0));
        scan_read(rb);
        check("rst_clear", 256'(rb), 256'(0));

        // Full scan loop with random contents.
        for (int i = 0; i < L; i++) rv[i] = 1'($urandom);
        scan_load(rv);
        scan_read(rb);
        check("scan_loop1", 256'(rb), 256'(rv));
        scan_read(rb2);
        check("scan_loop2", 256'(rb2), 256'(rv));

        // Random programs against the model.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NW; i++) begin
                a = 8'($urandom);
                // Make HLT rarer so runs last longer.
                if (a[7:4] == 4'hF && ($urandom_range(0, 3) != 0)) a[7:4] = 4'h7;
                m_mem[i] = a;
            end
            m_st = 0; m_pc = $urandom_range(0, NW - 1); m_ir = $urandom_range(0, 255);
            m_acc = $urandom_range(0, 255); m_c = $urandom_range(0, 1); m_io = 0;
            scan_load(pack(m_st, m_pc, m_ir, m_acc, m_c, m_io, m_mem));
            for (int cyc = 0; cyc < 40; cyc++) begin
                proc_en = ($urandom_range(0, 3) != 0);
                io_in = 8'($urandom);
                if (proc_en) model_step(int'(io_in));
                tick();
            end
            proc_en = 1'b0;
            check($sformatf("rand%0d_halt", t), 256'(halt), 256'(m_st >= 2));
            check($sformatf("rand%0d_io", t), 256'(io_out), 256'(m_io));
            scan_read(rb);
            check($sformatf("rand%0d_chain", t), 256'(rb),
                  256'(pack(m_st, m_pc, m_ir, m_acc, m_c, m_io, m_mem)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
